// File: rtl/axil_gpu_ctrl_regs_if.sv
// AXI-Lite bus bundle between the interconnect and the GPU control register block.
interface axil_gpu_ctrl_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_gpu_ctrl_regs.sv
// GPU and display control registers behind an AXI-Lite slave; turns register writes
// into queued single-cycle draw/clear/swap command pulses.
module axil_gpu_ctrl_regs #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STRB_WIDTH    = 4,
    parameter int REG_ADDR_BITS = 9
) (
    input  logic        clk,
    input  logic        rst,
    axil_gpu_ctrl_regs_if.slave s_axil,
    output logic [31:0] gpu_ctrl_address,
    output logic [15:0] gpu_ctrl_address_x,
    output logic [15:0] gpu_ctrl_address_y,
    output logic [15:0] gpu_ctrl_image_width,
    output logic [15:0] gpu_ctrl_width,
    output logic [15:0] gpu_ctrl_height,
    output logic [15:0] gpu_ctrl_x,
    output logic [15:0] gpu_ctrl_y,
    output logic [15:0] gpu_ctrl_clear_color,
    output logic        gpu_ctrl_draw,
    output logic        gpu_ctrl_clear,
    input  logic        gpu_busy,
    output logic        swap_buffers,
    output logic        is_vsynced,
    input  logic        hdmi_vsync
);
    localparam logic [REG_ADDR_BITS-1:0] OFF_ADDRESS     = REG_ADDR_BITS'('h000);
    localparam logic [REG_ADDR_BITS-1:0] OFF_ADDRESS_X   = REG_ADDR_BITS'('h004);
    localparam logic [REG_ADDR_BITS-1:0] OFF_ADDRESS_Y   = REG_ADDR_BITS'('h008);
    localparam logic [REG_ADDR_BITS-1:0] OFF_IMAGE_WIDTH = REG_ADDR_BITS'('h00C);
    localparam logic [REG_ADDR_BITS-1:0] OFF_WIDTH       = REG_ADDR_BITS'('h010);
    localparam logic [REG_ADDR_BITS-1:0] OFF_HEIGHT      = REG_ADDR_BITS'('h014);
    localparam logic [REG_ADDR_BITS-1:0] OFF_X           = REG_ADDR_BITS'('h018);
    localparam logic [REG_ADDR_BITS-1:0] OFF_Y           = REG_ADDR_BITS'('h01C);
    localparam logic [REG_ADDR_BITS-1:0] OFF_DRAW        = REG_ADDR_BITS'('h020);
    localparam logic [REG_ADDR_BITS-1:0] OFF_CLEAR_COLOR = REG_ADDR_BITS'('h024);
    localparam logic [REG_ADDR_BITS-1:0] OFF_CLEAR       = REG_ADDR_BITS'('h028);
    localparam logic [REG_ADDR_BITS-1:0] OFF_BUSY        = REG_ADDR_BITS'('h02C);
    localparam logic [REG_ADDR_BITS-1:0] OFF_SWAP        = REG_ADDR_BITS'('h100);
    localparam logic [REG_ADDR_BITS-1:0] OFF_VSYNC       = REG_ADDR_BITS'('h108);
    localparam logic [REG_ADDR_BITS-1:0] OFF_IS_VSYNCED  = REG_ADDR_BITS'('h10C);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Bus channel state
    logic                     aw_held_q, aw_held_d;
    logic [REG_ADDR_BITS-1:0] aw_off_q, aw_off_d;
    logic                     w_held_q, w_held_d;
    logic [31:0]              w_data_q, w_data_d;
    logic [3:0]               w_strb_q, w_strb_d;
    logic                     bvalid_q, bvalid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic                     rvalid_q, rvalid_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;

    // Register file and command state
    logic [31:0] address_q, address_d;
    logic [15:0] address_x_q, address_x_d, address_y_q, address_y_d;
    logic [15:0] image_width_q, image_width_d, width_q, width_d, height_q, height_d;
    logic [15:0] x_q, x_d, y_q, y_d, clear_color_q, clear_color_d;
    logic        is_vsynced_q, is_vsynced_d;
    logic        draw_pending_q, draw_pending_d, clear_pending_q, clear_pending_d;
    logic        swap_pending_q, swap_pending_d;
    logic        draw_q, draw_d, clear_q, clear_d, swap_q, swap_d;
    logic        vsync_prev_q, vsync_prev_d;

    logic                     wr_fire, wr_go, wr_legal;
    logic                     draw_req, clear_req, swap_req;
    logic                     draw_issue, clear_issue, swap_issue, vsync_rise;
    logic                     busy_flag;
    logic [REG_ADDR_BITS-1:0] rd_off;

    assign s_axil.awready = !rst && !aw_held_q && !bvalid_q;
    assign s_axil.wready  = !rst && !w_held_q && !bvalid_q;
    assign s_axil.arready = !rst && !rvalid_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    // Both holding registers full means the write executes this cycle.
    assign wr_fire = aw_held_q && w_held_q;
    assign wr_go   = wr_fire && (w_strb_q == 4'hF);

    always_comb begin
        address_d     = address_q;
        address_x_d   = address_x_q;
        address_y_d   = address_y_q;
        image_width_d = image_width_q;
        width_d       = width_q;
        height_d      = height_q;
        x_d           = x_q;
        y_d           = y_q;
        clear_color_d = clear_color_q;
        is_vsynced_d  = is_vsynced_q;
        draw_req      = 1'b0;
        clear_req     = 1'b0;
        swap_req      = 1'b0;
        wr_legal      = 1'b1;
        case (aw_off_q)
            OFF_ADDRESS:     if (wr_go) address_d     = w_data_q;
            OFF_ADDRESS_X:   if (wr_go) address_x_d   = w_data_q[15:0];
            OFF_ADDRESS_Y:   if (wr_go) address_y_d   = w_data_q[15:0];
            OFF_IMAGE_WIDTH: if (wr_go) image_width_d = w_data_q[15:0];
            OFF_WIDTH:       if (wr_go) width_d       = w_data_q[15:0];
            OFF_HEIGHT:      if (wr_go) height_d      = w_data_q[15:0];
            OFF_X:           if (wr_go) x_d           = w_data_q[15:0];
            OFF_Y:           if (wr_go) y_d           = w_data_q[15:0];
            OFF_CLEAR_COLOR: if (wr_go) clear_color_d = w_data_q[15:0];
            OFF_IS_VSYNCED:  if (wr_go) is_vsynced_d  = w_data_q[0];
            OFF_DRAW:        draw_req  = wr_go && w_data_q[0];
            OFF_CLEAR:       clear_req = wr_go && w_data_q[0];
            OFF_SWAP:        swap_req  = wr_go && w_data_q[0];
            default:         wr_legal  = 1'b0;
        endcase
    end

    always_comb begin
        aw_held_d = aw_held_q;
        aw_off_d  = aw_off_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (s_axil.awvalid && s_axil.awready) begin
            aw_held_d = 1'b1;
            aw_off_d  = {s_axil.awaddr[REG_ADDR_BITS-1:2], 2'b00};
        end
        if (s_axil.wvalid && s_axil.wready) begin
            w_held_d = 1'b1;
            w_data_d = s_axil.wdata;
            w_strb_d = s_axil.wstrb;
        end
        if (wr_fire) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (wr_go && wr_legal) ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axil.bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Clear wins over draw; draw also waits out the cycle the clear pulse is visible.
    assign vsync_rise  = hdmi_vsync && !vsync_prev_q;
    assign clear_issue = clear_pending_q && !gpu_busy;
    assign draw_issue  = draw_pending_q && !gpu_busy && !clear_pending_q && !clear_q;
    assign swap_issue  = swap_pending_q && (!is_vsynced_q || vsync_rise);
    assign busy_flag   = gpu_busy || draw_pending_q || clear_pending_q || swap_pending_q;

    always_comb begin
        draw_pending_d  = draw_req  ? 1'b1 : (draw_issue  ? 1'b0 : draw_pending_q);
        clear_pending_d = clear_req ? 1'b1 : (clear_issue ? 1'b0 : clear_pending_q);
        swap_pending_d  = swap_req  ? 1'b1 : (swap_issue  ? 1'b0 : swap_pending_q);
        draw_d          = draw_issue;
        clear_d         = clear_issue;
        swap_d          = swap_issue;
        vsync_prev_d    = hdmi_vsync;
    end

    assign rd_off = {s_axil.araddr[REG_ADDR_BITS-1:2], 2'b00};

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (s_axil.arvalid && s_axil.arready) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            case (rd_off)
                OFF_ADDRESS:     rdata_d = address_q;
                OFF_ADDRESS_X:   rdata_d = {16'h0, address_x_q};
                OFF_ADDRESS_Y:   rdata_d = {16'h0, address_y_q};
                OFF_IMAGE_WIDTH: rdata_d = {16'h0, image_width_q};
                OFF_WIDTH:       rdata_d = {16'h0, width_q};
                OFF_HEIGHT:      rdata_d = {16'h0, height_q};
                OFF_X:           rdata_d = {16'h0, x_q};
                OFF_Y:           rdata_d = {16'h0, y_q};
                OFF_CLEAR_COLOR: rdata_d = {16'h0, clear_color_q};
                OFF_BUSY:        rdata_d = {31'h0, busy_flag};
                OFF_VSYNC:       rdata_d = {31'h0, hdmi_vsync};
                OFF_IS_VSYNCED:  rdata_d = {31'h0, is_vsynced_q};
                default: begin
                    rdata_d = 32'h0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end else if (rvalid_q && s_axil.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q       <= 1'b0;
            aw_off_q        <= '0;
            w_held_q        <= 1'b0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            bvalid_q        <= 1'b0;
            bresp_q         <= '0;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            rresp_q         <= '0;
            address_q       <= '0;
            address_x_q     <= '0;
            address_y_q     <= '0;
            image_width_q   <= '0;
            width_q         <= '0;
            height_q        <= '0;
            x_q             <= '0;
            y_q             <= '0;
            clear_color_q   <= '0;
            is_vsynced_q    <= 1'b0;
            draw_pending_q  <= 1'b0;
            clear_pending_q <= 1'b0;
            swap_pending_q  <= 1'b0;
            draw_q          <= 1'b0;
            clear_q         <= 1'b0;
            swap_q          <= 1'b0;
            vsync_prev_q    <= 1'b0;
        end else begin
            aw_held_q       <= aw_held_d;
            aw_off_q        <= aw_off_d;
            w_held_q        <= w_held_d;
            w_data_q        <= w_data_d;
            w_strb_q        <= w_strb_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            rresp_q         <= rresp_d;
            address_q       <= address_d;
            address_x_q     <= address_x_d;
            address_y_q     <= address_y_d;
            image_width_q   <= image_width_d;
            width_q         <= width_d;
            height_q        <= height_d;
            x_q             <= x_d;
            y_q             <= y_d;
            clear_color_q   <= clear_color_d;
            is_vsynced_q    <= is_vsynced_d;
            draw_pending_q  <= draw_pending_d;
            clear_pending_q <= clear_pending_d;
            swap_pending_q  <= swap_pending_d;
            draw_q          <= draw_d;
            clear_q         <= clear_d;
            swap_q          <= swap_d;
            vsync_prev_q    <= vsync_prev_d;
        end
    end

    assign gpu_ctrl_address     = address_q;
    assign gpu_ctrl_address_x   = address_x_q;
    assign gpu_ctrl_address_y   = address_y_q;
    assign gpu_ctrl_image_width = image_width_q;
    assign gpu_ctrl_width       = width_q;
    assign gpu_ctrl_height      = height_q;
    assign gpu_ctrl_x           = x_q;
    assign gpu_ctrl_y           = y_q;
    assign gpu_ctrl_clear_color = clear_color_q;
    assign gpu_ctrl_draw        = draw_q;
    assign gpu_ctrl_clear       = clear_q;
    assign swap_buffers         = swap_q;
    assign is_vsynced           = is_vsynced_q;

    // Protection bits, byte-lane bits and alias bits above the decoded window are ignored.
    logic unused_bits;
    assign unused_bits = ^{s_axil.awprot, s_axil.arprot,
                           s_axil.awaddr[ADDR_WIDTH-1:REG_ADDR_BITS], s_axil.awaddr[1:0],
                           s_axil.araddr[ADDR_WIDTH-1:REG_ADDR_BITS], s_axil.araddr[1:0]};
endmodule

// File: tb/tb_axil_gpu_ctrl_regs.sv
// Directed bench for axil_gpu_ctrl_regs: bus timing, register map, command pulses, reset.
module tb_axil_gpu_ctrl_regs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_gpu_ctrl_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus ();

    logic [31:0] gpu_ctrl_address;
    logic [15:0] gpu_ctrl_address_x, gpu_ctrl_address_y, gpu_ctrl_image_width;
    logic [15:0] gpu_ctrl_width, gpu_ctrl_height, gpu_ctrl_x, gpu_ctrl_y, gpu_ctrl_clear_color;
    logic        gpu_ctrl_draw, gpu_ctrl_clear, swap_buffers, is_vsynced;
    logic        gpu_busy = 1'b0;
    logic        hdmi_vsync = 1'b0;

    axil_gpu_ctrl_regs dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_axil               (bus),
        .gpu_ctrl_address     (gpu_ctrl_address),
        .gpu_ctrl_address_x   (gpu_ctrl_address_x),
        .gpu_ctrl_address_y   (gpu_ctrl_address_y),
        .gpu_ctrl_image_width (gpu_ctrl_image_width),
        .gpu_ctrl_width       (gpu_ctrl_width),
        .gpu_ctrl_height      (gpu_ctrl_height),
        .gpu_ctrl_x           (gpu_ctrl_x),
        .gpu_ctrl_y           (gpu_ctrl_y),
        .gpu_ctrl_clear_color (gpu_ctrl_clear_color),
        .gpu_ctrl_draw        (gpu_ctrl_draw),
        .gpu_ctrl_clear       (gpu_ctrl_clear),
        .gpu_busy             (gpu_busy),
        .swap_buffers         (swap_buffers),
        .is_vsynced           (is_vsynced),
        .hdmi_vsync           (hdmi_vsync)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Pulse monitors, sampled mid-cycle
    int cyc = 0;
    int draw_cnt = 0, clear_cnt = 0, swap_cnt = 0;
    int draw_at = 0, clear_at = 0, swap_at = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (gpu_ctrl_draw)  begin draw_cnt++;  draw_at  = cyc; end
        if (gpu_ctrl_clear) begin clear_cnt++; clear_at = cyc; end
        if (swap_buffers)   begin swap_cnt++;  swap_at  = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        logic aw_hs, w_hs;
        n = 0;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            tick(1); n++;
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs)  bus.wvalid  = 1'b0;
        end
        while (!bus.bvalid && n < 20) begin tick(1); n++; end
        check("wr_bvalid", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
        tick(1);
        bus.bready = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        $display("WR addr=0x%08h data=0x%08h strb=%h resp=%0d", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        logic ar_hs;
        n = 0;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (bus.arvalid && n < 20) begin
            ar_hs = bus.arready;
            tick(1); n++;
            if (ar_hs) bus.arvalid = 1'b0;
        end
        while (!bus.rvalid && n < 20) begin tick(1); n++; end
        check("rd_rvalid", 32'(bus.rvalid), 32'd1);
        data = bus.rdata; resp = bus.rresp;
        tick(1);
        bus.rready = 1'b0; bus.arvalid = 1'b0;
        $display("RD addr=0x%08h data=0x%08h resp=%0d", addr, data, resp);
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;
    int d0, c0, s0, rise_at;

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        tick(3);
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_awready", 32'(bus.awready), 32'd1);
        check("post_rst_wready", 32'(bus.wready), 32'd1);
        check("post_rst_address", gpu_ctrl_address, 32'h0);

        // 1: AW and W together, bvalid one cycle after the holds are full
        bus.awaddr = 32'h000; bus.awvalid = 1'b1;
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
        tick(1);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("t1_awready_held", 32'(bus.awready), 32'd0);
        check("t1_bvalid_early", 32'(bus.bvalid), 32'd0);
        tick(1);
        check("t1_bvalid", 32'(bus.bvalid), 32'd1);
        check("t1_bresp", 32'(bus.bresp), 32'd0);
        check("t1_address", gpu_ctrl_address, 32'h12345678);
        bus.bready = 1'b1;
        tick(1);
        bus.bready = 1'b0;
        $display("WR addr=0x00000000 data=0x12345678 strb=f resp=0");
        check("t1_bvalid_done", 32'(bus.bvalid), 32'd0);
        check("t1_awready_back", 32'(bus.awready), 32'd1);
        axi_read(32'h000, rd, resp);
        check("t1_rdata", rd, 32'h12345678);
        check("t1_rresp", 32'(resp), 32'd0);

        // 2: W three cycles ahead of AW, B held off for four cycles
        bus.wdata = 32'hABCD1234; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick(1);
        bus.wvalid = 1'b0;
        check("t2_wready_held", 32'(bus.wready), 32'd0);
        check("t2_awready_open", 32'(bus.awready), 32'd1);
        tick(2);
        bus.awaddr = 32'h004; bus.awvalid = 1'b1;
        tick(1);
        bus.awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t2_bvalid_stable", 32'(bus.bvalid), 32'd1);
            check("t2_awready_low", 32'(bus.awready), 32'd0);
            check("t2_wready_low", 32'(bus.wready), 32'd0);
        end
        check("t2_address_x", 32'(gpu_ctrl_address_x), 32'h1234);
        bus.bready = 1'b1;
        tick(1);
        bus.bready = 1'b0;
        $display("WR addr=0x00000004 data=0xabcd1234 strb=f resp=0");
        check("t2_awready_back", 32'(bus.awready), 32'd1);
        axi_read(32'h004, rd, resp);
        check("t2_rdata_zext", rd, 32'h00001234);

        // 3: draw held off while the GPU is busy
        d0 = draw_cnt;
        gpu_busy = 1'b1;
        axi_write(32'h020, 32'h1, 4'hF, resp);
        check("t3_bresp", 32'(resp), 32'd0);
        tick(5);
        check("t3_no_draw", 32'(draw_cnt), 32'(d0));
        axi_read(32'h02C, rd, resp);
        check("t3_busy_1", rd, 32'h1);
        gpu_busy = 1'b0;
        tick(5);
        check("t3_one_draw", 32'(draw_cnt), 32'(d0 + 1));
        axi_read(32'h02C, rd, resp);
        check("t3_busy_0", rd, 32'h0);
        axi_write(32'h020, 32'h0, 4'hF, resp);
        tick(3);
        check("t3_draw0_noop", 32'(draw_cnt), 32'(d0 + 1));

        // clear queued alongside draw: clear issues first
        d0 = draw_cnt; c0 = clear_cnt;
        gpu_busy = 1'b1;
        axi_write(32'h028, 32'h1, 4'hF, resp);
        axi_write(32'h020, 32'h1, 4'hF, resp);
        gpu_busy = 1'b0;
        tick(6);
        check("t3_clear_cnt", 32'(clear_cnt), 32'(c0 + 1));
        check("t3_draw_cnt", 32'(draw_cnt), 32'(d0 + 1));
        check("t3_clear_first", 32'(draw_at > clear_at), 32'd1);

        // 4: swap waits for the vsync rising edge
        s0 = swap_cnt;
        axi_write(32'h10C, 32'h1, 4'hF, resp);
        check("t4_is_vsynced", 32'(is_vsynced), 32'd1);
        axi_write(32'h100, 32'h1, 4'hF, resp);
        hdmi_vsync = 1'b0;
        tick(10);
        check("t4_no_swap", 32'(swap_cnt), 32'(s0));
        axi_read(32'h02C, rd, resp);
        check("t4_busy_swap", rd, 32'h1);
        hdmi_vsync = 1'b1;
        rise_at = cyc;
        tick(4);
        check("t4_one_swap", 32'(swap_cnt), 32'(s0 + 1));
        check("t4_swap_timing", 32'(swap_at), 32'(rise_at + 1));
        axi_read(32'h108, rd, resp);
        check("t4_vsync_read", rd, 32'h1);
        axi_write(32'h10C, 32'h0, 4'hF, resp);
        s0 = swap_cnt;
        axi_write(32'h100, 32'h1, 4'hF, resp);
        tick(3);
        check("t4_swap_immediate", 32'(swap_cnt), 32'(s0 + 1));

        // 5: error responses
        axi_write(32'h018, 32'h0055, 4'hF, resp);
        axi_write(32'h018, 32'h0077, 4'h3, resp);
        check("t5_strb_bresp", 32'(resp), 32'h2);
        check("t5_x_unchanged", 32'(gpu_ctrl_x), 32'h0055);
        axi_write(32'h200, 32'hCAFE0000, 4'h3, resp);
        check("t5_200_bresp", 32'(resp), 32'h2);
        check("t5_addr_unchanged", gpu_ctrl_address, 32'h12345678);
        axi_write(32'h030, 32'h1, 4'hF, resp);
        check("t5_unmapped_bresp", 32'(resp), 32'h2);
        axi_write(32'h02C, 32'h1, 4'hF, resp);
        check("t5_ro_bresp", 32'(resp), 32'h2);
        axi_read(32'h020, rd, resp);
        check("t5_wo_rdata", rd, 32'h0);
        check("t5_wo_rresp", 32'(resp), 32'h2);

        // 6: reset with commands pending and read data waiting
        d0 = draw_cnt; s0 = swap_cnt;
        gpu_busy = 1'b1;
        hdmi_vsync = 1'b0;
        axi_write(32'h020, 32'h1, 4'hF, resp);
        axi_write(32'h10C, 32'h1, 4'hF, resp);
        axi_write(32'h100, 32'h1, 4'hF, resp);
        bus.araddr = 32'h000; bus.arvalid = 1'b1; bus.rready = 1'b0;
        tick(1);
        bus.arvalid = 1'b0;
        tick(1);
        check("t6_rvalid_before", 32'(bus.rvalid), 32'd1);
        rst = 1'b1;
        tick(1);
        check("t6_rvalid_rst", 32'(bus.rvalid), 32'd0);
        check("t6_arready_rst", 32'(bus.arready), 32'd0);
        check("t6_address_rst", gpu_ctrl_address, 32'h0);
        check("t6_is_vsynced_rst", 32'(is_vsynced), 32'd0);
        rst = 1'b0;
        gpu_busy = 1'b0;
        tick(2);
        hdmi_vsync = 1'b1;
        tick(8);
        check("t6_no_draw", 32'(draw_cnt), 32'(d0));
        check("t6_no_swap", 32'(swap_cnt), 32'(s0));
        axi_read(32'h02C, rd, resp);
        check("t6_busy_0", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
